// File: rtl/au_bitscan_ser_pkg.sv
// Shared AU constants: scan FSM states and the index-width helper.
// au_clog2 is the single place the index width is derived.
package au_bitscan_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int au_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/au_onehot_enc.sv
// One-hot to binary encoder; an all-zero input encodes to index 0.
// Purely combinational.
module au_onehot_enc
  import au_bitscan_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDXW = au_clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDXW-1:0]  idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) idx = idx | IDXW'(i);
    end
  end

endmodule

// File: rtl/au_bitscan_ser.sv
// Serialises the set-bit positions of each accepted mask, lowest first, one
// index beat per cycle; a zero mask yields a single beat flagged empty.
module au_bitscan_ser
  import au_bitscan_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDXW = au_clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             out_empty
);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $fatal(1, "au_bitscan_ser: WIDTH must be >= 2");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             empty_q, empty_d;

  logic [WIDTH-1:0] low_bit;
  logic [IDXW-1:0]  enc_idx;
  logic             scan;
  logic             last;

  // Two's-complement trick isolates the lowest set bit of the remainder.
  assign low_bit = rem_q & ((~rem_q) + WIDTH'(1));

  au_onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .onehot (low_bit),
    .idx    (enc_idx)
  );

  assign scan      = (state_q == SCAN);
  assign last      = empty_q | (rem_q == low_bit);
  assign in_ready  = ~scan;
  assign out_valid = scan;
  assign out_idx   = scan ? enc_idx : '0;
  assign out_last  = scan & last;
  assign out_empty = scan & empty_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    empty_d = empty_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = in_data;
          empty_d = (in_data == '0);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          rem_d = rem_q & ~low_bit;
          if (last) begin
            empty_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: tb/tb_au_bitscan_ser.sv
// Directed bench for au_bitscan_ser (WIDTH=8): inputs driven and outputs
// checked on the falling edge, expected values written out by hand.
module tb_au_bitscan_ser;

  localparam int WIDTH = 8;
  localparam int IDXW  = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_empty;

  int errors;
  int checks;

  au_bitscan_ser #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_empty (out_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_idx"},   32'(out_idx),   32'd0);
    chk({tag, ".out_last"},  32'(out_last),  32'd0);
    chk({tag, ".out_empty"}, 32'(out_empty), 32'd0);
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic last, input logic empty);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd0);
    chk({tag, ".out_idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".out_last"},  32'(out_last),  32'(last));
    chk({tag, ".out_empty"}, 32'(out_empty), 32'(empty));
  endtask

  // Offer one word for a single cycle; returns at the first beat's falling edge.
  task automatic send(input logic [WIDTH-1:0] data);
    in_valid = 1'b1;
    in_data  = data;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");

    // A4: beats 2, 5, 7 back to back
    out_ready = 1'b1;
    send(8'hA4);
    chk_beat("a4_b0", 2, 1'b0, 1'b0); @(negedge clk);
    chk_beat("a4_b1", 5, 1'b0, 1'b0); @(negedge clk);
    chk_beat("a4_b2", 7, 1'b1, 1'b0); @(negedge clk);
    chk_idle("a4_done");

    // Zero word: one empty beat
    send(8'h00);
    chk_beat("zero_b0", 0, 1'b1, 1'b1); @(negedge clk);
    chk_idle("zero_done");

    // FF: eight beats, ready again 9 cycles after accept
    send(8'hFF);
    for (int i = 0; i < 8; i++) begin
      chk_beat($sformatf("ff_b%0d", i), i, (i == 7), 1'b0);
      @(negedge clk);
    end
    chk_idle("ff_done");

    // 12 with backpressure on the first beat
    out_ready = 1'b0;
    send(8'h12);
    for (int k = 0; k < 3; k++) begin
      chk_beat($sformatf("bp_hold%0d", k), 1, 1'b0, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk_beat("bp_hold3", 1, 1'b0, 1'b0); @(negedge clk);
    chk_beat("bp_b1", 4, 1'b1, 1'b0);    @(negedge clk);
    chk_idle("bp_done");

    // F0 interrupted by reset after the first beat
    send(8'hF0);
    chk_beat("rst_b0", 4, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst_mid");
    send(8'h01);
    chk_beat("rst_new", 0, 1'b1, 1'b0); @(negedge clk);
    chk_idle("rst_new_done");

    // in_valid held high with changing data during a scan
    in_valid = 1'b1;
    in_data  = 8'hA4;
    @(negedge clk);
    in_data = 8'hFF;
    chk_beat("ovl_b0", 2, 1'b0, 1'b0); @(negedge clk);
    in_data = 8'h01;
    chk_beat("ovl_b1", 5, 1'b0, 1'b0); @(negedge clk);
    in_data = 8'h00;
    chk_beat("ovl_b2", 7, 1'b1, 1'b0); @(negedge clk);
    chk_idle("ovl_done");
    in_valid = 1'b0;
    @(negedge clk);
    chk_idle("ovl_quiet");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/au_bitscan_ser.md
AU_BITSCAN_SER -- requirements
Module: AU_bitscan_ser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length of the input mask (>= 2).
REQ-002 SHALL derive localparam IDXW = ceil(log2(WIDTH)), meaning the output index width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-004 SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning input word offered.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning block can accept a word.
REQ-007 SHALL have port in_data, input, WIDTH bits, meaning the mask to scan.
REQ-008 SHALL have port out_valid, output, 1 bit, meaning an index beat is presented.
REQ-009 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts a beat.
REQ-010 SHALL have port out_idx, output, IDXW bits, meaning the bit position of the current set bit.
REQ-011 SHALL have port out_last, output, 1 bit, meaning final beat of the current word.
REQ-012 SHALL have port out_empty, output, 1 bit, meaning the accepted word was all zeros.

Function
REQ-013 SHALL implement states IDLE and SCAN, plus a WIDTH-bit remainder register rem and an empty-flag register.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL, in IDLE with in_valid=1, load rem<=in_data, set empty<=(in_data==0), and go to SCAN; the first beat is valid the next cycle (latency 1).
REQ-016 SHALL drive out_valid=1 throughout SCAN and 0 in IDLE.
REQ-017 SHALL, in SCAN with empty=0, drive out_idx = position of the lowest set bit of rem, isolated as rem & (~rem+1) and then binary-encoded.
REQ-018 SHALL drive out_last=1 when rem has exactly one set bit, or when empty=1.
REQ-019 SHALL, in SCAN with empty=1, emit exactly one beat with out_idx=0, out_last=1, out_empty=1.
REQ-020 SHALL, on out_valid&out_ready, clear the reported bit in rem; if out_last=1, return to IDLE.
REQ-021 SHALL hold out_idx, out_last and out_empty stable while out_valid=1 and out_ready=0.
REQ-022 SHALL emit indices strictly ascending, one beat per set bit, with no gaps under continuous out_ready=1.
REQ-023 SHALL drive out_empty=0 on every beat of a nonzero word.
REQ-024 SHALL ignore in_valid and in_data during SCAN; no overlap of words.
REQ-025 SHALL produce per-word throughput of popcount+1 cycles (1 accept cycle plus beats), or 2 cycles for a zero word.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, enter IDLE and clear rem and empty, taking priority over all handshakes, including mid-scan.
REQ-027 SHALL drive these outputs the cycle after reset: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_empty=0.
REQ-028 SHALL discard the remaining indices of a word interrupted by reset; they are never emitted.

Structure
REQ-029 SHALL place the IDXW derivation (clog2 function) in the shared AU constants include file, not duplicated locally.
REQ-030 SHALL implement one-hot-to-binary encoding in one sub-module, AU_onehot_enc (WIDTH in, IDXW out).
REQ-031 SHALL check parameters at elaboration: WIDTH < 2 SHALL print an error and abort simulation.

Verification (WIDTH=8)
REQ-032 SHALL cover: in_data=8'hA4, out_ready=1 -> beats idx 2, 5, 7 on consecutive cycles; last=1 on idx 7 only; in_ready=1 the cycle after.
REQ-033 SHALL cover: in_data=8'h00 -> single beat idx=0, last=1, empty=1; back to IDLE.
REQ-034 SHALL cover: in_data=8'hFF -> 8 consecutive beats idx 0..7, last on 7; 9 cycles from accept to next in_ready.
REQ-035 SHALL cover: in_data=8'h12 with out_ready low for 3 cycles on the first beat -> idx=1 held stable 4 cycles; then idx 4 with last=1.
REQ-036 SHALL cover: in_data=8'hF0, rst asserted after the first beat (idx 4) -> next cycle out_valid=0, in_ready=1; a new word 8'h01 yields idx 0 with last=1.
REQ-037 SHALL cover: in_valid held high during SCAN with changing in_data -> no effect on the emitted sequence.
